fifo_stream_reader: RTL and testbench

Read-side drain engine for the team's single-clock fifo. It issues rdreq to the FIFO and absorbs the FIFO read latency (showahead, normal or registered-output). It delivers words on a valid/ready stream with full throughput and no FIFO underflow. It sits between a fifo instance (q_o/empty_o/rdreq_i) and any downstream stream consumer.

---
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a single-clock fifo onto a valid/ready stream, hiding the fifo read latency.
// Latency: RD_LATENCY+1 cycles from first readable cycle to valid_o; sustains one word per clock.
// Backpressure: ready_i low holds data_o/valid_o; reads are issued only against free skid-buffer credit.
module fifo_stream_reader #(
  parameter int DWIDTH     = 8,
  parameter int RD_LATENCY = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 en_i,
  input  logic [DWIDTH-1:0]    fifo_q_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rdreq_o,
  output logic [DWIDTH-1:0]    data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] words_o
);
  // One buffer slot per cycle of read latency plus one, so credit never starves a full-rate stream.
  localparam int BUF_DEPTH = RD_LATENCY + 1;
  // Shift register width; latency 0 keeps a single always-zero bit so the logic stays uniform.
  localparam int SR_W = (RD_LATENCY == 0) ? 1 : RD_LATENCY;
  localparam logic [2:0] DEPTH_C = 3'(BUF_DEPTH);

  logic [DWIDTH-1:0]    buf_q [BUF_DEPTH];
  logic [DWIDTH-1:0]    buf_d [BUF_DEPTH];
  logic [2:0]           occ_q, occ_d;
  logic [2:0]           inflight, inflight_d;
  logic [2:0]           wr_idx;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic                 pop, capture;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] words_q;

  // Head of the shift-style buffer is a register, so data_o comes straight off a flop.
  assign valid_o = (occ_q != 3'd0);
  assign data_o  = buf_q[0];
  assign busy_o  = busy_q;
  assign words_o = words_q;
  assign pop     = valid_o && ready_i;

  // Issue a read only if the word has a guaranteed slot; a same-cycle pop frees its slot immediately.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SR_W; i++) inflight = inflight + {2'b00, sr_q[i]};
    fifo_rdreq_o = !srst_i && en_i && !fifo_empty_i &&
                   ((occ_q + inflight - {2'b00, pop}) < DEPTH_C);
  end

  // Track issued reads to their capture edge, and compute buffer shift/insert for this edge.
  always_comb begin
    sr_d    = '0;
    capture = fifo_rdreq_o;
    if (RD_LATENCY != 0) begin
      sr_d[0] = fifo_rdreq_o;
      for (int i = 1; i < SR_W; i++) sr_d[i] = sr_q[i-1];
      capture = sr_q[SR_W-1];
    end
    inflight_d = '0;
    for (int i = 0; i < SR_W; i++) inflight_d = inflight_d + {2'b00, sr_d[i]};
    occ_d  = occ_q + {2'b00, capture} - {2'b00, pop};
    wr_idx = pop ? (occ_q - 3'd1) : occ_q;
    for (int i = 0; i < BUF_DEPTH; i++) buf_d[i] = buf_q[i];
    if (pop) begin
      for (int i = 0; i + 1 < BUF_DEPTH; i++) buf_d[i] = buf_q[i+1];
    end
    if (capture) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_idx == 3'(i)) buf_d[i] = fifo_q_i;
      end
    end
  end

  // State registers; reset drops in-flight reads and buffered words together with the fifo.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      occ_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
      words_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      occ_q  <= occ_d;
      sr_q   <= sr_d;
      busy_q <= (occ_d != 3'd0) || (inflight_d != 3'd0);
      if (pop) words_q <= words_q + CNT_WIDTH'(1);
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: four readers (latency 0/1/2, plus latency 0 with a 4-bit counter) fed by fifo models.
// Latency: not applicable; stimulus is shared, each instance has its own fifo model and scoreboard.
// Backpressure: ready pattern driven from vector table, directed sequences and $urandom.
module tb_fifo_stream_reader;
  logic       clk   = 1'b0;
  logic       srst  = 1'b1;
  logic       en    = 1'b0;
  logic       ready = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] wdata = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         nwr    = 0;

  logic        rdreq [4];
  logic        valid [4];
  logic        busy  [4];
  logic        fe    [4];
  logic [7:0]  dout  [4];
  logic [7:0]  fq    [4];
  logic [15:0] words [4];
  int          n_iss [4];
  int          n_del [4];

  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 1) ? 1 : (k == 2) ? 2 : 0;
  endfunction

  function automatic int cw(input int k);
    return (k == 3) ? 4 : 16;
  endfunction

  task automatic check(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [inst %0d]: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_inst
      localparam int L  = (g == 1) ? 1 : (g == 2) ? 2 : 0;
      localparam int CW = (g == 3) ? 4 : 16;
      logic [CW-1:0] w;
      logic [7:0]    fm [1024];
      int            fh = 0;
      int            ft = 0;
      logic [7:0]    q1 = 8'h00;
      logic [7:0]    q2 = 8'h00;
      logic          prev_stall = 1'b0;
      logic [7:0]    prev_d = 8'h00;

      fifo_stream_reader #(.DWIDTH(8), .RD_LATENCY(L), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .srst_i(srst), .en_i(en), .fifo_q_i(fq[g]), .fifo_empty_i(fe[g]),
        .fifo_rdreq_o(rdreq[g]), .data_o(dout[g]), .valid_o(valid[g]), .ready_i(ready),
        .busy_o(busy[g]), .words_o(w));

      assign words[g] = 16'(w);
      assign fe[g]    = (fh == ft);
      assign fq[g]    = (L == 0) ? fm[fh[9:0]] : (L == 1) ? q1 : q2;

      // fifo model: showahead / normal / normal+registered output; fm also serves as the expected stream
      always @(posedge clk) begin
        if (srst) begin
          fh <= 0; ft <= 0; q1 <= 8'h00; q2 <= 8'h00; n_iss[g] <= 0; n_del[g] <= 0;
        end else begin
          if (wr && ft < 1024) begin fm[ft] <= wdata; ft <= ft + 1; end
          if (rdreq[g] && fh != ft) begin q1 <= fm[fh]; fh <= fh + 1; end
          q2 <= q1;
          if (rdreq[g]) n_iss[g] <= n_iss[g] + 1;
          if (valid[g] && ready) n_del[g] <= n_del[g] + 1;
        end
      end

      // per-cycle stream rules checked away from the active edge
      always @(negedge clk) begin
        if (!srst) begin
          check(g, "no_rdreq_when_empty", 64'(rdreq[g] && fe[g]), 64'd0);
          check(g, "outstanding_le_depth", 64'((n_iss[g] - n_del[g]) <= L + 1), 64'd1);
          check(g, "words_count", 64'(words[g]), 64'(n_del[g] % (1 << CW)));
          if (prev_stall) begin
            check(g, "stall_valid_held", 64'(valid[g]), 64'd1);
            check(g, "stall_data_held", 64'(dout[g]), 64'(prev_d));
          end
          if (valid[g] && ready) begin
            check(g, "delivered_was_written", 64'(n_del[g] < ft), 64'd1);
            if (n_del[g] < ft) check(g, "delivered_order", 64'(dout[g]), 64'(fm[n_del[g]]));
          end
          prev_stall = valid[g] && !ready;
          prev_d     = dout[g];
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  endgenerate

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rdy;
    logic [2:0] ev;   // expected valid_o, bit index = read latency
    logic [2:0] er;   // expected fifo_rdreq_o, bit index = read latency
    logic       eb;   // expected busy_o (same for every latency here)
    logic [7:0] ed;   // expected data_o where valid
  } vec_t;
  vec_t tbl [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1; wr = 1'b0; en = 1'b0; ready = 1'b0;
    step();
    step();
    srst = 1'b0;
    nwr  = 0;
  endtask

  task automatic prefill(input logic [7:0] base, input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr = 1'b1; wdata = base + 8'(i);
      step();
    end
    wr = 1'b0;
  endtask

  function automatic bit all_del(input int n);
    for (int k = 0; k < 4; k++) if (n_del[k] < n) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first [4];
    int   run   [4];
    bit   got   [4];

    tbl[0] = '{1'b1, 8'h11, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 3'b000, 3'b111, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 3'b001, 3'b110, 1'b1, 8'h11};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 3'b011, 3'b000, 1'b1, 8'h11};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 3'b111, 3'b001, 1'b1, 8'h11};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 3'b111, 3'b000, 1'b1, 8'h22};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00};

    // reset values
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check(k, "reset_valid", 64'(valid[k]), 64'd0);
      check(k, "reset_busy", 64'(busy[k]), 64'd0);
      check(k, "reset_words", 64'(words[k]), 64'd0);
      check(k, "reset_data", 64'(dout[k]), 64'd0);
      check(k, "reset_rdreq", 64'(rdreq[k]), 64'd0);
    end

    // vector table: two words, a two-cycle stall, then drain
    en = 1'b1;
    for (int r = 0; r < 7; r++) begin
      wr = tbl[r].wr; wdata = tbl[r].wd; ready = tbl[r].rdy;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        check(k, $sformatf("vec%0d_valid", r), 64'(valid[k]), 64'(tbl[r].ev[lat(k)]));
        check(k, $sformatf("vec%0d_rdreq", r), 64'(rdreq[k]), 64'(tbl[r].er[lat(k)]));
        check(k, $sformatf("vec%0d_busy", r), 64'(busy[k]), 64'(tbl[r].eb));
        if (tbl[r].ev[lat(k)]) check(k, $sformatf("vec%0d_data", r), 64'(dout[k]), 64'(tbl[r].ed));
      end
      @(posedge clk); #1;
    end
    wr = 1'b0;

    // 16-word burst: first valid RD_LATENCY+1 cycles after enable, then 16 back-to-back
    do_reset();
    prefill(8'h00, 16);
    en = 1'b1; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin first[k] = -1; run[k] = 0; end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (valid[k]) begin
          if (first[k] < 0) first[k] = c;
          if (c - first[k] == run[k]) run[k]++;
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      check(k, "first_valid_latency", 64'(first[k]), 64'(lat(k) + 1));
      check(k, "burst_no_bubbles", 64'(run[k]), 64'd16);
      check(k, "burst_words", 64'(words[k]), 64'(16 % (1 << cw(k))));
    end

    // backpressure 1,0,0,1 over 0xA0..0xAF
    do_reset();
    prefill(8'hA0, 16);
    en = 1'b1;
    for (int c = 0; c < 200 && !all_del(16); c++) begin
      ready = ((c % 4) == 0) || ((c % 4) == 3);
      step();
    end
    ready = 1'b1;
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      check(k, "bp_delivered", 64'(n_del[k]), 64'd16);
      check(k, "bp_words", 64'(words[k]), 64'(16 % (1 << cw(k))));
    end

    // enable dropped after 5 reads, then resumed
    do_reset();
    prefill(8'h00, 16);
    ready = 1'b1; en = 1'b1;
    repeat (5) step();
    en = 1'b0;
    repeat (10) step();
    for (int k = 0; k < 4; k++) begin
      check(k, "en_drop_issued", 64'(n_iss[k]), 64'd5);
      check(k, "en_drop_delivered", 64'(n_del[k]), 64'd5);
      check(k, "en_drop_valid", 64'(valid[k]), 64'd0);
      check(k, "en_drop_busy", 64'(busy[k]), 64'd0);
      check(k, "en_drop_words", 64'(words[k]), 64'd5);
      got[k] = 1'b0;
    end
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (valid[k] && !got[k]) begin
          check(k, "resume_data", 64'(dout[k]), 64'h05);
          got[k] = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) check(k, "resume_seen", 64'(got[k]), 64'd1);

    // reset with 2 words buffered and 1 in flight (latency-2 instance)
    do_reset();
    prefill(8'h30, 8);
    ready = 1'b0; en = 1'b1;
    repeat (4) step();
    check(2, "pre_reset_valid", 64'(valid[2]), 64'd1);
    check(2, "pre_reset_data", 64'(dout[2]), 64'h30);
    check(2, "pre_reset_outstanding", 64'(n_iss[2] - n_del[2]), 64'd3);
    srst = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      check(k, "mid_reset_valid", 64'(valid[k]), 64'd0);
      check(k, "mid_reset_busy", 64'(busy[k]), 64'd0);
      check(k, "mid_reset_words", 64'(words[k]), 64'd0);
      got[k] = 1'b0;
    end
    srst = 1'b0; ready = 1'b1; en = 1'b1;
    wr = 1'b1; wdata = 8'h5A;
    step();
    wr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (valid[k] && !got[k]) begin
          check(k, "post_reset_first_data", 64'(dout[k]), 64'h5A);
          got[k] = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) check(k, "post_reset_seen", 64'(got[k]), 64'd1);

    // 20 transfers: 4-bit counter wraps and ends at 4
    do_reset();
    prefill(8'h40, 20);
    en = 1'b1; ready = 1'b1;
    repeat (30) step();
    for (int k = 0; k < 4; k++) check(k, "wrap_words", 64'(words[k]), 64'(20 % (1 << cw(k))));
    check(3, "wrap_words_cnt4", 64'(words[3]), 64'd4);

    // randomized traffic against the fifo models and scoreboards
    do_reset();
    for (int c = 0; c < 600; c++) begin
      wr    = (nwr < 900) && ($urandom_range(0, 1) == 1);
      wdata = 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 7) != 0);
      if (wr) nwr++;
      step();
    end
    wr = 1'b0; en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 1200 && !all_del(nwr); c++) step();
    step();
    for (int k = 0; k < 4; k++) begin
      check(k, "rand_all_delivered", 64'(n_del[k]), 64'(nwr));
      check(k, "rand_idle_valid", 64'(valid[k]), 64'd0);
      check(k, "rand_idle_busy", 64'(busy[k]), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
